// File: rtl/register_bank_if.sv
// Processor-side access bus of the register bank: one strobe-qualified access per
// cycle, registered read response with valid and address-error pulses.
interface register_bank_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
);
  logic                  chip_enable;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;
  logic                  addr_error;

  modport master (
    output chip_enable, write_enable, address, write_data,
    input  read_data, read_valid, addr_error
  );

  modport slave (
    input  chip_enable, write_enable, address, write_data,
    output read_data, read_valid, addr_error
  );
endinterface

// File: rtl/register_bank.sv
// Memory-mapped register block: GPR file, LED register, synchronised switches and
// debounced buttons with sticky W1C press events and a registered interrupt.
module register_bank #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 5,
  parameter int NUM_GPR         = 8,
  parameter int NUM_LED         = 8,
  parameter int NUM_SWITCH      = 8,
  parameter int NUM_BUTTON      = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  register_bank_if.slave        bus,
  output logic [NUM_LED-1:0]    led_out,
  input  logic [NUM_SWITCH-1:0] switch_in,
  input  logic [NUM_BUTTON-1:0] button_in,
  output logic                  button_irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [ADDR_WIDTH-1:0] A_LED   = ADDR_WIDTH'(NUM_GPR);
  localparam logic [ADDR_WIDTH-1:0] A_SW    = ADDR_WIDTH'(NUM_GPR + 1);
  localparam logic [ADDR_WIDTH-1:0] A_LEVEL = ADDR_WIDTH'(NUM_GPR + 2);
  localparam logic [ADDR_WIDTH-1:0] A_EVENT = ADDR_WIDTH'(NUM_GPR + 3);

  logic [DATA_WIDTH-1:0] r_gpr [NUM_GPR];
  logic [NUM_LED-1:0]    r_led;
  logic [NUM_SWITCH-1:0] r_sw_meta, r_sw_sync;
  logic [NUM_BUTTON-1:0] r_btn_meta, r_btn_sync;
  logic [CNT_W-1:0]      r_cnt [NUM_BUTTON];
  logic [NUM_BUTTON-1:0] r_level;
  logic [NUM_BUTTON-1:0] r_event;
  logic                  r_irq;

  logic [DATA_WIDTH-1:0] r_rdata_p1;
  logic                  r_vld_p1;
  logic                  r_err_p1;

  logic                  w_wr;
  logic                  w_rd;
  logic [DATA_WIDTH-1:0] w_rd_mux;
  logic                  w_mapped;
  logic                  w_writable;
  logic [NUM_BUTTON-1:0] w_evt_clr;
  logic [NUM_BUTTON-1:0] w_differ;
  logic [NUM_BUTTON-1:0] w_accept;
  logic [NUM_BUTTON-1:0] w_rise;

  assign w_wr = bus.chip_enable &  bus.write_enable;
  assign w_rd = bus.chip_enable & ~bus.write_enable;

  // Address decode: read mux plus mapped/writable classification of the access.
  always_comb begin
    w_rd_mux   = '0;
    w_mapped   = 1'b0;
    w_writable = 1'b0;
    for (int i = 0; i < NUM_GPR; i++) begin
      if (bus.address == ADDR_WIDTH'(i)) begin
        w_rd_mux   = r_gpr[i];
        w_mapped   = 1'b1;
        w_writable = 1'b1;
      end
    end
    if (bus.address == A_LED) begin
      w_rd_mux   = DATA_WIDTH'(r_led);
      w_mapped   = 1'b1;
      w_writable = 1'b1;
    end else if (bus.address == A_SW) begin
      w_rd_mux = DATA_WIDTH'(r_sw_sync);
      w_mapped = 1'b1;
    end else if (bus.address == A_LEVEL) begin
      w_rd_mux = DATA_WIDTH'(r_level);
      w_mapped = 1'b1;
    end else if (bus.address == A_EVENT) begin
      w_rd_mux   = DATA_WIDTH'(r_event);
      w_mapped   = 1'b1;
      w_writable = 1'b1;
    end
  end

  assign w_evt_clr = (w_wr && bus.address == A_EVENT) ? bus.write_data[NUM_BUTTON-1:0] : '0;

  // A button is accepted on the edge its counter would reach DEBOUNCE_CYCLES.
  always_comb begin
    w_differ = r_btn_sync ^ r_level;
    w_accept = '0;
    for (int b = 0; b < NUM_BUTTON; b++) begin
      w_accept[b] = w_differ[b] && (r_cnt[b] == CNT_LAST);
    end
    w_rise = w_accept & r_btn_sync;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_GPR; i++) r_gpr[i] <= '0;
      r_led <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (bus.address == ADDR_WIDTH'(i)) r_gpr[i] <= bus.write_data;
      end
      if (bus.address == A_LED) r_led <= bus.write_data[NUM_LED-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_btn_meta <= '0;
      r_btn_sync <= '0;
      r_level    <= '0;
      r_event    <= '0;
      r_irq      <= 1'b0;
      for (int b = 0; b < NUM_BUTTON; b++) r_cnt[b] <= '0;
    end else begin
      r_sw_meta  <= switch_in;
      r_sw_sync  <= r_sw_meta;
      r_btn_meta <= button_in;
      r_btn_sync <= r_btn_meta;
      r_level    <= r_level ^ w_accept;
      // A new press outranks a simultaneous clear of the same bit.
      r_event    <= (r_event & ~w_evt_clr) | w_rise;
      r_irq      <= |r_event;
      for (int b = 0; b < NUM_BUTTON; b++) begin
        if (!w_differ[b] || w_accept[b]) r_cnt[b] <= '0;
        else                             r_cnt[b] <= r_cnt[b] + CNT_W'(1);
      end
    end
  end

  // Stage p1: registered read response; data holds between reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdata_p1 <= '0;
      r_vld_p1   <= 1'b0;
      r_err_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= w_rd;
      r_err_p1 <= bus.chip_enable & (bus.write_enable ? ~w_writable : ~w_mapped);
      if (w_rd) r_rdata_p1 <= w_rd_mux;
    end
  end

  assign bus.read_data  = r_rdata_p1;
  assign bus.read_valid = r_vld_p1;
  assign bus.addr_error = r_err_p1;
  assign led_out        = r_led;
  assign button_irq     = r_irq;

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: directed accesses with literal expectations plus a
// per-cycle comparison against a history-based behavioural model.
module tb_register_bank;
  localparam int DW = 16, AW = 5, G = 8, NL = 8, NS = 8, NB = 4, D = 4;

  logic          clock;
  logic          reset;
  logic [NS-1:0] switch_in;
  logic [NB-1:0] button_in;
  logic [NL-1:0] led_out;
  logic          button_irq;

  register_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  register_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_GPR(G), .NUM_LED(NL),
    .NUM_SWITCH(NS), .NUM_BUTTON(NB), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .led_out(led_out),
    .switch_in(switch_in), .button_in(button_in), .button_irq(button_irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural model: register contents, pin histories and the last D synchronised
  // button samples; a level flips once all D samples disagree with it.
  logic [DW-1:0] m_gpr [G];
  logic [NL-1:0] m_led;
  logic [NS-1:0] m_sw_h [2];
  logic [NB-1:0] m_bt_h [2];
  logic [NB-1:0] m_samp [D];
  logic [NB-1:0] m_lvl, m_evt;
  logic [DW-1:0] m_rd;
  logic          m_rv, m_err, m_irq;

  initial begin
    int            a;
    logic [DW-1:0] rv;
    logic          mapped, writable, all_diff;
    logic [NB-1:0] clr, rise;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        for (int i = 0; i < G; i++) m_gpr[i] = '0;
        for (int j = 0; j < D; j++) m_samp[j] = '0;
        m_sw_h[0] = '0; m_sw_h[1] = '0; m_bt_h[0] = '0; m_bt_h[1] = '0;
        m_led = '0; m_lvl = '0; m_evt = '0;
        m_rd = '0; m_rv = 1'b0; m_err = 1'b0; m_irq = 1'b0;
      end else begin
        a = int'(bus.address);
        mapped = 1'b1; writable = 1'b1;
        if (a < G)           rv = m_gpr[a];
        else if (a == G)     rv = DW'(m_led);
        else if (a == G + 1) begin rv = DW'(m_sw_h[1]); writable = 1'b0; end
        else if (a == G + 2) begin rv = DW'(m_lvl);     writable = 1'b0; end
        else if (a == G + 3) rv = DW'(m_evt);
        else begin rv = '0; mapped = 1'b0; writable = 1'b0; end
        m_rv  = bus.chip_enable && !bus.write_enable;
        if (m_rv) m_rd = rv;
        m_err = bus.chip_enable && (bus.write_enable ? !writable : !mapped);
        m_irq = |m_evt;
        clr = '0;
        if (bus.chip_enable && bus.write_enable) begin
          if (a < G)           m_gpr[a] = bus.write_data;
          else if (a == G)     m_led = bus.write_data[NL-1:0];
          else if (a == G + 3) clr = bus.write_data[NB-1:0];
        end
        for (int j = D - 1; j > 0; j--) m_samp[j] = m_samp[j-1];
        m_samp[0] = m_bt_h[1];
        rise = '0;
        for (int b = 0; b < NB; b++) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++) if (m_samp[j][b] == m_lvl[b]) all_diff = 1'b0;
          if (all_diff) begin
            m_lvl[b] = ~m_lvl[b];
            rise[b]  = m_lvl[b];
          end
        end
        m_evt = (m_evt & ~clr) | rise;
        m_sw_h[1] = m_sw_h[0]; m_sw_h[0] = switch_in;
        m_bt_h[1] = m_bt_h[0]; m_bt_h[0] = button_in;
      end
    end
  end

  initial begin
    @(negedge clock);
    forever begin
      @(negedge clock);
      check("model read_valid", 32'(bus.read_valid), 32'(m_rv));
      check("model read_data",  32'(bus.read_data),  32'(m_rd));
      check("model addr_error", 32'(bus.addr_error), 32'(m_err));
      check("model led_out",    32'(led_out),        32'(m_led));
      check("model button_irq", 32'(button_irq),     32'(m_irq));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.chip_enable = 1'b1; bus.write_enable = 1'b1;
    bus.address = addr; bus.write_data = data;
    @(posedge clock);
    #1;
    bus.chip_enable = 1'b0; bus.write_enable = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    bus.chip_enable = 1'b1; bus.write_enable = 1'b0; bus.address = addr;
    @(posedge clock);
    #1;
    bus.chip_enable = 1'b0;
    check({name, " data"},  32'(bus.read_data),  32'(exp));
    check({name, " valid"}, 32'(bus.read_valid), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus.chip_enable = 1'b0; bus.write_enable = 1'b0;
    bus.address = '0; bus.write_data = '0;
    switch_in = '0; button_in = '0;
    idle(3);
    check("reset read_data",  32'(bus.read_data),  32'd0);
    check("reset read_valid", 32'(bus.read_valid), 32'd0);
    check("reset led_out",    32'(led_out),        32'd0);
    check("reset irq",        32'(button_irq),     32'd0);
    reset = 1'b0;

    // GPR write/read, valid pulse width, data hold
    do_write(5'd3, 16'hBEEF);
    do_read("gpr3", 5'd3, 16'hBEEF);
    idle(1);
    check("valid drops", 32'(bus.read_valid), 32'd0);
    check("data holds",  32'(bus.read_data),  32'hBEEF);
    do_read("gpr0", 5'd0, 16'h0000);

    // LED register truncation / zero-extension
    do_write(5'd8, 16'hFFA5);
    check("led_out", 32'(led_out), 32'hA5);
    do_read("led", 5'd8, 16'h00A5);

    // Switch synchroniser and read-only protection
    switch_in = 8'h3C;
    idle(2);
    do_read("switch", 5'd9, 16'h003C);
    do_write(5'd9, 16'h1234);
    check("sw write err", 32'(bus.addr_error), 32'd1);
    idle(1);
    check("sw err pulse", 32'(bus.addr_error), 32'd0);
    do_read("switch after wr", 5'd9, 16'h003C);

    // Three-sample glitch is rejected
    button_in = 4'h4;
    idle(3);
    button_in = 4'h0;
    idle(8);
    do_read("glitch level", 5'd10, 16'h0000);
    do_read("glitch event", 5'd11, 16'h0000);

    // Held press: level flips on the sixth edge, irq one cycle after the event
    button_in = 4'h4;
    idle(5);
    do_read("level edge6", 5'd10, 16'h0000);
    check("irq lags", 32'(button_irq), 32'd0);
    do_read("event set", 5'd11, 16'h0004);
    check("irq rises", 32'(button_irq), 32'd1);
    do_read("level set", 5'd10, 16'h0004);

    // W1C: writing 0 keeps, writing 1 clears, irq follows a cycle later
    do_write(5'd11, 16'h0000);
    do_read("event w0 keeps", 5'd11, 16'h0004);
    do_write(5'd11, 16'h0004);
    check("irq still up", 32'(button_irq), 32'd1);
    do_read("event cleared", 5'd11, 16'h0000);
    check("irq falls", 32'(button_irq), 32'd0);

    // Set wins over a same-edge clear
    button_in = 4'h0;
    idle(8);
    button_in = 4'h4;
    idle(5);
    do_write(5'd11, 16'h0004);
    do_read("set beats clear", 5'd11, 16'h0004);
    check("irq after set", 32'(button_irq), 32'd1);
    do_write(5'd11, 16'h0004);
    idle(1);
    check("irq after clr", 32'(button_irq), 32'd0);

    // Unmapped read
    do_read("unmapped", 5'd31, 16'h0000);
    check("unmapped err", 32'(bus.addr_error), 32'd1);
    idle(1);
    check("unmapped err pulse", 32'(bus.addr_error), 32'd0);

    // Reset while a read response is outstanding
    bus.chip_enable = 1'b1; bus.write_enable = 1'b0; bus.address = 5'd3;
    @(posedge clock);
    #1;
    bus.chip_enable = 1'b0;
    check("pending valid", 32'(bus.read_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid reset valid", 32'(bus.read_valid), 32'd0);
    check("mid reset data",  32'(bus.read_data),  32'd0);
    check("mid reset led",   32'(led_out),        32'd0);
    check("mid reset irq",   32'(button_irq),     32'd0);
    idle(2);
    reset = 1'b0;

    // Button held through reset release: debounced afresh from level 0
    do_read("gpr3 after reset", 5'd3, 16'h0000);
    idle(4);
    do_read("held evt edge6", 5'd11, 16'h0000);
    do_read("held evt edge7", 5'd11, 16'h0004);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
